// File: rtl/io_arbiter.sv
// io_arbiter: round-robin arbiter sharing one IO device between NREQ requesters.
// Four-state FSM: IDLE select, ISSUE strobe, WAIT for ready/timeout, RESP done.
module io_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*64-1:0]   req_wdata,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [63:0]          rdata,
  output logic [63:0]          dev_in_data,
  output logic                 dev_in_signal,
  output logic                 dev_out_signal,
  input  logic                 dev_in_ready,
  input  logic                 dev_out_ready,
  input  logic [63:0]          dev_out_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   last;
  logic [IW-1:0]   sel;
  logic            found;
  logic            sel_wr;
  logic [63:0]     sel_wdata;
  logic            wr;
  logic [7:0]      timer;
  logic            ready_sel;
  logic            tmo;
  logic [NREQ-1:0] own;

  assign ready_sel = wr ? dev_in_ready : dev_out_ready;
  assign tmo       = (timer == 8'(TIMEOUT - 1));
  assign own       = NREQ'(1) << idx;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    logic [IW-1:0] c;
    found = 1'b0;
    sel   = '0;
    c     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      c = IW'((int'(last) + k) % NREQ);
      if (!found && req[c]) begin
        found = 1'b1;
        sel   = c;
      end
    end
  end

  // Pick direction and write data of the selected requester.
  always_comb begin
    sel_wr    = 1'b0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == IW'(i)) begin
        sel_wr    = req_write[i];
        sel_wdata = req_wdata[64*i +: 64];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (ready_sel || tmo) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Transaction latches, timer, response capture and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      last        <= IW'(NREQ - 1);
      wr          <= 1'b0;
      timer       <= '0;
      err         <= 1'b0;
      rdata       <= '0;
      dev_in_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            idx         <= sel;
            wr          <= sel_wr;
            dev_in_data <= sel_wdata;
          end
        end
        ISSUE: timer <= '0;
        WAIT: begin
          if (ready_sel) begin
            err <= 1'b0;
            if (!wr) rdata <= dev_out_data;
          end else if (tmo) begin
            err <= 1'b1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        RESP: last <= idx;
        default: ;
      endcase
    end
  end

  // Outputs decoded from the state register and the latched owner.
  always_comb begin
    grant          = (state == ISSUE || state == WAIT) ? own : '0;
    done           = (state == RESP) ? own : '0;
    dev_in_signal  = (state == ISSUE) && wr;
    dev_out_signal = (state == ISSUE) && !wr;
  end

endmodule

// File: tb/tb_io_arbiter.sv
// tb_io_arbiter: table-driven transactions with a done-side scoreboard,
// plus hand-written reset-abort and continuous round-robin sequences.
module tb_io_arbiter;

  localparam int N  = 4;
  localparam int TO = 4;
  localparam logic [63:0] K = 64'h0100_0000_0000_0000;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    req_write;
  logic [N*64-1:0] req_wdata;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            err;
  logic [63:0]     rdata;
  logic [63:0]     dev_in_data;
  logic            dev_in_signal;
  logic            dev_out_signal;
  logic            dev_in_ready;
  logic            dev_out_ready;
  logic [63:0]     dev_out_data;

  io_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_write(req_write),
    .req_wdata(req_wdata), .grant(grant), .done(done), .err(err),
    .rdata(rdata), .dev_in_data(dev_in_data),
    .dev_in_signal(dev_in_signal), .dev_out_signal(dev_out_signal),
    .dev_in_ready(dev_in_ready), .dev_out_ready(dev_out_ready),
    .dev_out_data(dev_out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req;
    bit           wr;
    logic [63:0]  wdata;
    logic [63:0]  ddata;
    int           d;
    bit           drop;
    bit           wrong;
    int           eidx;
    bit           eerr;
    logic [63:0]  erd;
  } vec_t;

  typedef struct {
    int          idx;
    bit          err;
    logic [63:0] rd;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [N-1:0] r, input bit w,
      input logic [63:0] wd, input logic [63:0] dd, input int d,
      input bit drop, input bit wrong, input int ei, input bit ee,
      input logic [63:0] er);
    vec_t v;
    v.req = r; v.wr = w; v.wdata = wd; v.ddata = dd; v.d = d;
    v.drop = drop; v.wrong = wrong; v.eidx = ei; v.eerr = ee; v.erd = er;
    return v;
  endfunction

  // Scoreboard: every done pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (mon_en && done !== '0) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got %b expected none", done);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_done", 64'(done), 64'(N'(1) << e.idx));
        chk("sb_err", 64'(err), 64'(e.err));
        chk("sb_rdata", rdata, e.rd);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_rdata"}, rdata, 64'd0);
    chk({tag, "_din"}, dev_in_data, 64'd0);
    chk({tag, "_sig"}, {62'd0, dev_in_signal, dev_out_signal}, 64'd0);
  endtask

  task automatic run(input vec_t v);
    exp_t e;
    int   lat;
    int   wc;
    bit   seen;
    bit   got;
    lat  = (v.d >= 0) ? 4 + v.d : 3 + TO;
    seen = 1'b0;
    got  = 1'b0;
    wc   = -1;
    req  = v.req;
    req_write = {N{v.wr}};
    for (int i = 0; i < N; i++)
      req_wdata[64*i +: 64] = v.wdata + 64'(i) * K;
    dev_out_data = v.ddata;
    e.idx = v.eidx; e.err = v.eerr; e.rd = v.erd;
    q.push_back(e);
    for (int n = 1; n <= 40; n++) begin
      step();
      if (dev_in_signal || dev_out_signal) begin
        chk("strobe_lat", 64'(n), 64'd1);
        chk("strobe_excl", 64'(dev_in_signal & dev_out_signal), 64'd0);
        chk("strobe_dir", 64'(dev_in_signal), 64'(v.wr));
        chk("grant", 64'(grant), 64'(N'(1) << v.eidx));
        if (v.wr)
          chk("din_issue", dev_in_data, v.wdata + 64'(v.eidx) * K);
        seen = 1'b1;
        wc   = -1;
        if (v.drop) begin
          req       = '0;
          req_write = ~req_write;
          req_wdata = '1;
        end
      end else if (seen) begin
        wc++;
      end
      if (seen && wc >= 0) begin
        dev_in_ready  = (v.wr && !v.wrong && wc == v.d) ||
                        (!v.wr && v.wrong);
        dev_out_ready = (!v.wr && !v.wrong && wc == v.d) ||
                        (v.wr && v.wrong);
      end
      if (done !== '0) begin
        chk("done_lat", 64'(n + 1), 64'(lat));
        if (v.wr)
          chk("din_hold", dev_in_data, v.wdata + 64'(v.eidx) * K);
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_wait: got no done expected idx %0d", v.eidx);
    end
    dev_in_ready  = 1'b0;
    dev_out_ready = 1'b0;
    req = '0;
    step();
    chk("done_pulse", 64'(done), 64'd0);
  endtask

  vec_t tv[9];

  initial begin
    int t_done[5];
    int nd;
    tv[0] = mk(4'b0001, 1, 64'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 64'h0);
    tv[1] = mk(4'b0100, 0, 0, 64'h1234, 2, 0, 0, 2, 0, 64'h1234);
    tv[2] = mk(4'b0100, 0, 0, 64'h9999, -1, 0, 0, 2, 1, 64'h1234);
    tv[3] = mk(4'b0100, 0, 0, 64'h5555, 3, 0, 0, 2, 0, 64'h5555);
    tv[4] = mk(4'b1001, 1, 64'h0A0B, 0, 1, 0, 0, 3, 0, 64'h5555);
    tv[5] = mk(4'b1001, 1, 64'h0C0D, 0, 0, 0, 0, 0, 0, 64'h5555);
    tv[6] = mk(4'b0011, 0, 0, 64'hAAAA, 0, 1, 0, 1, 0, 64'hAAAA);
    tv[7] = mk(4'b0001, 1, 64'h7777, 0, -1, 0, 0, 0, 1, 64'hAAAA);
    tv[8] = mk(4'b1000, 0, 0, 64'hBBBB, -1, 0, 1, 3, 1, 64'hAAAA);

    reset = 1'b1;
    req = '0; req_write = '0; req_wdata = '0;
    dev_in_ready = 1'b0; dev_out_ready = 1'b0; dev_out_data = '0;
    step();
    step();
    check_zero("rst");
    reset = 1'b0;
    mon_en = 1'b1;

    foreach (tv[i]) run(tv[i]);

    req = 4'b0100;
    req_write = '0;
    step();
    step();
    step();
    chk("pre_rst_grant", 64'(grant), 64'b0100);
    reset = 1'b1;
    req = '0;
    step();
    check_zero("mid_rst");
    reset = 1'b0;
    repeat (6) step();
    run(mk(4'b0010, 1, 64'h0F0F, 0, 0, 0, 0, 1, 0, 64'h0));

    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      e.idx = i % N; e.err = 1'b0; e.rd = 64'h0;
      q.push_back(e);
    end
    req = '1;
    req_write = '1;
    dev_in_ready = 1'b1;
    nd = 0;
    for (int c = 0; c < 60 && nd < 5; c++) begin
      step();
      if (done !== '0) begin
        t_done[nd] = c;
        nd++;
        if (nd == 5) req = '0;
      end
    end
    chk("rr_count", 64'(nd), 64'd5);
    for (int i = 1; i < nd; i++)
      chk("rr_spacing", 64'(t_done[i] - t_done[i-1]), 64'd4);
    dev_in_ready = 1'b0;
    repeat (3) step();
    chk("rr_idle", 64'(grant), 64'd0);
    chk("sb_empty", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
